// File: rtl/prog_ram_arbiter.sv
// rtl/prog_ram_arbiter.sv - round-robin fetch/loader arbiter in front of the single-port program RAM
// Define PRA_WRITE_PROTECT_EN to reject loader writes to the lowest PROTECT_WORDS words.
module prog_ram_arbiter #(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 32,
   parameter int PROTECT_WORDS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req_i,
   input  logic [ADDR_W-1:0] f_addr_i,
   output logic              f_gnt_o,
   output logic              f_rvalid_o,
   output logic [DATA_W-1:0] f_rdata_o,
   input  logic              l_req_i,
   input  logic              l_we_i,
   input  logic [ADDR_W-1:0] l_addr_i,
   input  logic [DATA_W-1:0] l_wdata_i,
   output logic              l_gnt_o,
   output logic              l_rvalid_o,
   output logic [DATA_W-1:0] l_rdata_o,
   output logic              l_err_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

`ifdef PRA_WRITE_PROTECT_EN
   localparam bit PROTECT_ON = 1'b1;
`else
   localparam bit PROTECT_ON = 1'b0;
`endif
   localparam logic [ADDR_W:0] PROT_LIMIT = (ADDR_W+1)'(PROTECT_WORDS);

   state_e            state_q;
   logic              last_fetch_q;
   logic              blocked_q;
   logic              f_gnt_q, l_gnt_q, f_rvalid_q, l_rvalid_q, l_err_q;
   logic              ram_en_q, ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;

   logic              win_fetch_d;
   logic              blocked_d;

   // Fetch wins unless the loader is also asking and fetch won last time.
   assign win_fetch_d = f_req_i & (~l_req_i | ~last_fetch_q);
   assign blocked_d   = PROTECT_ON & ~win_fetch_d & l_we_i & ({1'b0, l_addr_i} < PROT_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_fetch_q <= 1'b0;
         blocked_q    <= 1'b0;
         f_gnt_q      <= 1'b0;
         l_gnt_q      <= 1'b0;
         f_rvalid_q   <= 1'b0;
         l_rvalid_q   <= 1'b0;
         l_err_q      <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         f_gnt_q    <= 1'b0;
         l_gnt_q    <= 1'b0;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         l_err_q    <= 1'b0;
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         case (state_q)
            S_ISSUE: begin
               state_q    <= S_RESP;
               f_rvalid_q <= last_fetch_q;
               l_rvalid_q <= ~last_fetch_q;
               l_err_q    <= blocked_q;
            end
            default: begin
               // IDLE and RESP both arbitrate, so RESP can chain straight into ISSUE.
               if (f_req_i | l_req_i) begin
                  state_q      <= S_ISSUE;
                  last_fetch_q <= win_fetch_d;
                  blocked_q    <= blocked_d;
                  f_gnt_q      <= win_fetch_d;
                  l_gnt_q      <= ~win_fetch_d;
                  ram_en_q     <= 1'b1;
                  ram_we_q     <= ~win_fetch_d & l_we_i & ~blocked_d;
                  ram_addr_q   <= win_fetch_d ? f_addr_i : l_addr_i;
                  ram_wdata_q  <= win_fetch_d ? '0 : l_wdata_i;
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign f_gnt_o     = f_gnt_q;
   assign l_gnt_o     = l_gnt_q;
   assign f_rvalid_o  = f_rvalid_q;
   assign l_rvalid_o  = l_rvalid_q;
   assign l_err_o     = l_err_q;
   assign ram_en_o    = ram_en_q;
   assign ram_we_o    = ram_we_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;
   assign busy_o      = (state_q != S_IDLE);
   assign f_rdata_o   = f_rvalid_q ? ram_rdata_i : '0;
   assign l_rdata_o   = l_rvalid_q ? ram_rdata_i : '0;

endmodule

// File: tb/tb_prog_ram_arbiter.sv
// tb/tb_prog_ram_arbiter.sv - randomized self-checking bench for prog_ram_arbiter against a transaction model
module tb_prog_ram_arbiter;

`ifdef PRA_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req, f_gnt, f_rvalid;
   logic [7:0]  f_addr;
   logic [31:0] f_rdata;
   logic        l_req, l_we, l_gnt, l_rvalid, l_err;
   logic [7:0]  l_addr;
   logic [31:0] l_wdata, l_rdata;
   logic        ram_en, ram_we, busy;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] ram [256];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prog_ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
      .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
      .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata), .l_err_o(l_err),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata), .busy_o(busy)
   );

   function automatic logic [31:0] init_val(input int a);
      return (a == 5) ? 32'hDEADBEEF : ((32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000);
   endfunction

   // Program RAM macro: synchronous read-first single port.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      end else if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         ram_rdata <= ram[ram_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: timeline of issue cycles plus a shadow memory.
   int          cyc, last_issue;
   bit          m_last_fetch, cur_fetch, cur_we, cur_blk;
   logic [7:0]  cur_addr;
   logic [31:0] cur_wdata;
   logic [31:0] mem_m [256];
   bit          e_fgnt, e_lgnt, e_fv, e_lv, e_err, e_en, e_we, e_busy;
   logic [7:0]  e_addr;
   logic [31:0] e_wdata, e_rdata;
   int          p_f, p_l, p_drop;

   task automatic new_f();
      f_req  = 1'b1;
      f_addr = 8'($urandom_range(0, 31));
   endtask

   task automatic new_l();
      l_req   = 1'b1;
      l_we    = 1'($urandom_range(0, 1));
      l_addr  = 8'($urandom_range(0, 31));
      l_wdata = $urandom;
   endtask

   task automatic step();
      @(negedge clk);
      check_eq("f_gnt", f_gnt, e_fgnt);
      check_eq("l_gnt", l_gnt, e_lgnt);
      check_eq("f_rvalid", f_rvalid, e_fv);
      check_eq("l_rvalid", l_rvalid, e_lv);
      check_eq("l_err", l_err, e_err);
      check_eq("ram_en", ram_en, e_en);
      check_eq("busy", busy, e_busy);
      if (e_en) begin
         check_eq("ram_addr", ram_addr, e_addr);
         check_eq("ram_we", ram_we, e_we);
         if (e_we) check_eq("ram_wdata", ram_wdata, e_wdata);
      end
      if (e_fv) check_eq("f_rdata", f_rdata, e_rdata);
      if (e_lv && !cur_we) check_eq("l_rdata", l_rdata, e_rdata);

      if (f_req) begin
         if (e_fgnt) begin
            if ($urandom_range(0, 99) < p_f) new_f(); else f_req = 1'b0;
         end else if ($urandom_range(0, 99) < p_drop) f_req = 1'b0;
      end else if ($urandom_range(0, 99) < p_f) new_f();
      if (l_req) begin
         if (e_lgnt) begin
            if ($urandom_range(0, 99) < p_l) new_l(); else l_req = 1'b0;
         end else if ($urandom_range(0, 99) < p_drop) l_req = 1'b0;
      end else if ($urandom_range(0, 99) < p_l) new_l();

      {e_fgnt, e_lgnt, e_fv, e_lv, e_err, e_en, e_we, e_busy} = '0;
      if (cyc == last_issue) begin
         e_fv    = cur_fetch;
         e_lv    = !cur_fetch;
         e_err   = cur_blk;
         e_busy  = 1'b1;
         e_rdata = mem_m[cur_addr];
         if (cur_we && !cur_blk) mem_m[cur_addr] = cur_wdata;
      end else if (f_req || l_req) begin
         cur_fetch    = f_req && (!l_req || !m_last_fetch);
         m_last_fetch = cur_fetch;
         cur_addr     = cur_fetch ? f_addr : l_addr;
         cur_we       = !cur_fetch && l_we;
         cur_wdata    = l_wdata;
         cur_blk      = PROT && cur_we && (cur_addr < 8'd16);
         last_issue   = cyc + 1;
         e_fgnt  = cur_fetch;
         e_lgnt  = !cur_fetch;
         e_en    = 1'b1;
         e_we    = cur_we && !cur_blk;
         e_addr  = cur_addr;
         e_wdata = cur_wdata;
         e_busy  = 1'b1;
      end
      cyc++;
   endtask

   initial begin
      rst_n = 1'b0;
      {f_req, l_req, l_we} = '0;
      f_addr = '0; l_addr = '0; l_wdata = '0;
      for (int i = 0; i < 256; i++) mem_m[i] = init_val(i);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_f_gnt", f_gnt, 0);
      check_eq("rst_l_gnt", l_gnt, 0);
      check_eq("rst_f_rvalid", f_rvalid, 0);
      check_eq("rst_l_rvalid", l_rvalid, 0);
      check_eq("rst_l_err", l_err, 0);
      check_eq("rst_ram_en", ram_en, 0);
      check_eq("rst_ram_we", ram_we, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_busy", busy, 0);

      rst_n  = 1'b1;
      f_req  = 1'b1;
      f_addr = 8'h05;
      @(negedge clk);
      check_eq("mid_f_gnt", f_gnt, 1);
      check_eq("mid_ram_addr", ram_addr, 8'h05);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_f_gnt", f_gnt, 0);
      check_eq("mid_rst_ram_en", ram_en, 0);
      check_eq("mid_rst_ram_addr", ram_addr, 0);
      check_eq("mid_rst_busy", busy, 0);
      f_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("post_rst_f_rvalid", f_rvalid, 0);
         check_eq("post_rst_busy", busy, 0);
      end

      cyc = 0; last_issue = -10; m_last_fetch = 1'b0;
      cur_we = 1'b0; cur_fetch = 1'b0; cur_blk = 1'b0; cur_addr = '0; cur_wdata = '0;
      {e_fgnt, e_lgnt, e_fv, e_lv, e_err, e_en, e_we, e_busy} = '0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;

      p_f = 100; p_l = 100; p_drop = 0;
      repeat (40) step();
      p_f = 50; p_l = 50; p_drop = 10;
      repeat (3000) step();
      p_f = 100; p_l = 0; p_drop = 0;
      repeat (40) step();
      p_f = 0; p_l = 0;
      repeat (6) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/prog_ram_arbiter.md
Name: prog_ram_arbiter

Overview:
Shares the single-port synchronous program RAM between two requesters. The core's instruction fetch path (f_*) is read-only. The program loader/debug port (l_*) can read and write. Round-robin arbitration; one RAM access per two cycles; registered grant and response handshakes. Sits between the core sequencer's fetch stage and the program RAM macro.

Parameters:
ADDR_W, 8, program RAM word-address width
DATA_W, 32, instruction word width
PROTECT_WORDS, 16, number of low words write-protected when PRA_WRITE_PROTECT_EN is defined

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request; held until f_gnt
f_addr  in  ADDR_W  fetch word address; stable while f_req high
f_gnt  out  1  one-cycle pulse: fetch request issued to RAM
f_rvalid  out  1  one-cycle pulse: f_rdata valid
f_rdata  out  DATA_W  fetch read data
l_req  in  1  loader request; held until l_gnt
l_we  in  1  loader write enable (1=write, 0=read)
l_addr  in  ADDR_W  loader word address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  one-cycle pulse: loader request issued
l_rvalid  out  1  one-cycle pulse: loader read data valid / write acknowledged
l_rdata  out  DATA_W  loader read data
l_err  out  1  one-cycle pulse with l_rvalid: write rejected (feature only)
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en
busy  out  1  high in ISSUE and RESP

Behaviour:
- Reset: clk, rst_n async active-low. State IDLE, last_winner=loader (fetch wins first tie). All outputs 0. Any access in flight is dropped; no rvalid after reset.
- States: IDLE, ISSUE, RESP. All control outputs are registered from state.
- IDLE: if any req is high, pick a winner and go to ISSUE; otherwise stay in IDLE.
- ISSUE (1 cycle): winner's gnt=1, ram_en=1, ram_addr/ram_we/ram_wdata = winner's captured request. Fetch always has ram_we=0. Next state is RESP unconditionally.
- RESP (1 cycle): winner's rvalid=1; its rdata = ram_rdata. Arbitrate again: any req high goes to ISSUE (back-to-back), otherwise IDLE.
- Requester contract: drop or change req the cycle after seeing gnt. The arbiter never samples req during ISSUE.
- Request capture: address, we and wdata are latched on the clock edge entering ISSUE.
- Arbitration, both requesting: winner is the requester that is not last_winner. last_winner updates on entry to ISSUE.
- Arbitration, single requester: that requester wins. No idle bubble beyond the RESP cycle.
- Throughput: at most 1 access per 2 cycles. Latency from req sampled in IDLE: gnt at +1 cycle, rvalid at +2 cycles.
- Loader write: l_rvalid still pulses in RESP as a write acknowledge; l_rdata is don't-care.
- The non-winning rvalid/gnt stay 0. f_rdata/l_rdata may mirror ram_rdata at all times; they are only meaningful with rvalid.
- req deasserted before grant: it is simply not serviced. No error is raised.
- Addresses wrap naturally at 2^ADDR_W; no range check.

Optional Feature:
PRA_WRITE_PROTECT_EN
- Defined: a loader write with l_addr < PROTECT_WORDS is still granted and acknowledged. ram_en=1 and ram_we=0 in ISSUE, so RAM contents are unchanged. l_err pulses with l_rvalid in RESP.
- Not defined: all writes proceed. l_err is tied 0.

Test Plan:
- Reset mid-access: f_req=1 addr 0x05, assert rst_n=0 during ISSUE -> all outputs 0 next cycle, no f_rvalid, state IDLE after release.
- Single fetch: RAM[0x05]=0xDEADBEEF, f_req 1 cycle before edge -> f_gnt at +1, ram_addr=0x05 ram_we=0, f_rvalid at +2 with f_rdata=0xDEADBEEF.
- Loader write then read: write 0x12345678 to 0x20, then read 0x20 -> l_gnt/l_rvalid each access, read returns 0x12345678, l_err=0.
- Contention: f_req and l_req held high continuously from reset -> grants alternate F,L,F,L, one per 2 cycles, busy continuously high.
- Back-to-back same requester: fetch issues requests to 0x00,0x01,0x02 with req re-raised in each RESP -> ISSUE every other cycle, no IDLE cycles.
- Write protect (feature on, PROTECT_WORDS=16): loader writes 0xFFFFFFFF to 0x03 -> l_gnt, ram_we=0, l_rvalid with l_err=1, later read of 0x03 returns original value. With the feature off, the same write lands and l_err=0.
